// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and read sequencer in front of a single-port data memory.
// Port 0 is the core load/store path, port 1 the debug/loader master (with burst lock).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              core_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a master holds req (with we/addr/wdata stable) until the
  // combinational gnt; the access is taken in the gnt cycle. Reads return
  // later as a one-cycle rvalid pulse with rdata registered alongside it.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RET  = 2'd2
  } state_e;

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic arb_en;
  logic win1;
  logic rd_grant;
  logic rd_done;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= 2'd0;
      owner_q     <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // Next-state logic: RD_RET arbitrates like IDLE, so back-to-back reads chain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RD_RET: state_d = rd_grant ? RD_WAIT : IDLE;
      RD_WAIT:      if (cnt_q == 2'd0) state_d = RD_RET;
      default:      state_d = IDLE;
    endcase
  end

  // Output logic: arbitration, memory strobes and stall.
  always_comb begin
    arb_en   = rst && (state_q != RD_WAIT);
    win1     = m1_req && (m1_lock || !m0_req || prio_q);
    m0_gnt   = arb_en && m0_req && !win1;
    m1_gnt   = arb_en && win1;
    mem_en   = m0_gnt || m1_gnt;
    mem_we   = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
    rd_grant = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    rd_done  = (state_q == RD_WAIT) && (cnt_q == 2'd0);
    // The core is frozen from its read grant until the data-return cycle.
    core_stall = (m0_req && !m0_gnt) || (m0_gnt && !m0_we) ||
                 ((state_q == RD_WAIT) && !owner_q);
  end

  // Datapath: priority rotation, latency counter and read-data return.
  always_comb begin
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    // A locked port-1 grant keeps priority on port 1 for the rest of the burst.
    if (m0_gnt) begin
      prio_d = 1'b1;
    end else if (m1_gnt) begin
      prio_d = m1_lock;
    end

    if (rd_grant) begin
      cnt_d   = CNT_LOAD;
      owner_d = m1_gnt;
    end else if ((state_q == RD_WAIT) && (cnt_q != 2'd0)) begin
      cnt_d = cnt_q - 2'd1;
    end

    if (rd_done) begin
      if (owner_q) begin
        m1_rdata_d  = mem_rdata;
        m1_rvalid_d = 1'b1;
      end else begin
        m0_rdata_d  = mem_rdata;
        m0_rvalid_d = 1'b1;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with a
// memory responder, a cycle-level reference model, directed scenarios and random traffic.
module tb_dmem_arbiter;

  logic clk;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, core_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    string       pfx;
    bit          done = 1'b0;
    logic [31:0] mem_arr [64];
    int          cyc = 0;

    // reference model state, expressed in absolute cycle numbers
    bit          mdl_prio = 1'b0;
    int          blk_until = -1;
    int          ret_cyc = -1;
    bit          ret_port = 1'b0;
    logic [31:0] ret_data = '0;
    logic [31:0] exp_rdata0 = '0, exp_rdata1 = '0;
    bit          exp_gnt0 = 1'b0, exp_gnt1 = 1'b0;
    int          rd_due = -1;
    logic [31:0] rd_data = '0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .core_stall(core_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Memory responder + model compare, once per cycle mid-period.
    always @(negedge clk) begin : cmp
      bit          g0, g1, can, rv0, rv1, e_we, e_stall, pend0;
      logic [31:0] e_addr, e_wdata;
      cyc = cyc + 1;
      mem_rdata = (cyc == rd_due) ? rd_data : $urandom;

      g0 = 1'b0; g1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
      e_we = 1'b0; e_addr = '0; e_wdata = '0;
      if (!rst_n) begin
        mdl_prio = 1'b0; blk_until = -1; ret_cyc = -1;
        exp_rdata0 = '0; exp_rdata1 = '0; rd_due = -1;
        e_stall = m0_req;
      end else begin
        if (cyc == ret_cyc) begin
          if (ret_port) begin rv1 = 1'b1; exp_rdata1 = ret_data; end
          else          begin rv0 = 1'b1; exp_rdata0 = ret_data; end
        end
        pend0 = (ret_cyc > cyc) && !ret_port;
        can = cyc > blk_until;
        if (can) begin
          if (m1_req && (m1_lock || !m0_req || mdl_prio)) g1 = 1'b1;
          else if (m0_req) g0 = 1'b1;
        end
        if (g1) begin e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata; end
        if (g0) begin e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata; end
        e_stall = (m0_req && !g0) || (g0 && !m0_we) || pend0;
      end

      chk({pfx, "_m0_gnt"},  32'(m0_gnt),  32'(g0));
      chk({pfx, "_m1_gnt"},  32'(m1_gnt),  32'(g1));
      chk({pfx, "_mem_en"},  32'(mem_en),  32'(g0 | g1));
      chk({pfx, "_mem_we"},  32'(mem_we),  32'(e_we));
      chk({pfx, "_mem_addr"}, mem_addr, e_addr);
      chk({pfx, "_mem_wdata"}, mem_wdata, e_wdata);
      chk({pfx, "_m0_rvalid"}, 32'(m0_rvalid), 32'(rv0));
      chk({pfx, "_m1_rvalid"}, 32'(m1_rvalid), 32'(rv1));
      chk({pfx, "_m0_rdata"}, m0_rdata, exp_rdata0);
      chk({pfx, "_m1_rdata"}, m1_rdata, exp_rdata1);
      chk({pfx, "_core_stall"}, 32'(core_stall), 32'(e_stall));

      if (g0 || g1) begin
        mdl_prio = g0 ? 1'b1 : m1_lock;
        if (!e_we) begin
          blk_until = cyc + LAT;
          ret_cyc   = cyc + LAT + 1;
          ret_port  = g1;
          ret_data  = mem_arr[e_addr[5:0]];
        end
      end
      exp_gnt0 = g0;
      exp_gnt1 = g1;

      if (rst_n && mem_en) begin
        if (mem_we) mem_arr[mem_addr[5:0]] = mem_wdata;
        else begin
          rd_due  = cyc + LAT;
          rd_data = mem_arr[mem_addr[5:0]];
        end
      end
    end

    initial begin : stim
      int          t_gnt, t_rv, stall_n, rv_n;
      logic [7:0]  seq;
      pfx = $sformatf("lat%0d", LAT);
      rst_n = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
      for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // idle after reset release
      @(negedge clk);
      chk({pfx, "_idle_ctl"}, 32'({m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid, core_stall}), 32'd0);
      chk({pfx, "_idle_addr"}, mem_addr | mem_wdata, 32'd0);
      chk({pfx, "_idle_rdata"}, m0_rdata | m1_rdata, 32'd0);
      chk({pfx, "_idle_state"}, 32'(dbg_state), 32'd0);

      // m0 write 0x10
      @(posedge clk); #1;
      m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk({pfx, "_wr_strobes"}, 32'({m0_gnt, mem_en, mem_we}), 32'd7);
      chk({pfx, "_wr_addr"}, mem_addr, 32'h10);
      chk({pfx, "_wr_data"}, mem_wdata, 32'hDEADBEEF);

      // m0 read 0x10: rvalid LAT+1 cycles after grant, stall for LAT+1 cycles
      @(posedge clk); #1;
      m0_we = 0; m0_wdata = '0;
      @(negedge clk);
      chk({pfx, "_rd_gnt"}, 32'(m0_gnt), 32'd1);
      stall_n = int'(core_stall); rv_n = 0; t_rv = -1;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        m0_req = 0;
        @(negedge clk);
        stall_n += int'(core_stall);
        if (m0_rvalid) begin
          rv_n++;
          if (t_rv < 0) begin
            t_rv = k;
            chk({pfx, "_rd_data"}, m0_rdata, 32'hDEADBEEF);
          end
        end
      end
      chk({pfx, "_rd_latency"}, 32'(t_rv), 32'(LAT + 1));
      chk({pfx, "_rd_pulses"}, 32'(rv_n), 32'd1);
      chk({pfx, "_rd_stall_cycles"}, 32'(stall_n), 32'(LAT + 1));
      chk({pfx, "_rd_hold"}, m0_rdata, 32'hDEADBEEF);

      // reset (stall follows m0_req), then alternating writes
      @(posedge clk); #1;
      rst_n = 0; m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hA5A50001;
      @(negedge clk);
      chk({pfx, "_rst_stall"}, 32'({core_stall, m0_gnt, mem_en}), 32'd4);
      @(posedge clk); #1;
      rst_n = 1; m1_req = 1; m1_we = 1; m1_addr = 32'h24; m1_wdata = 32'h0BADF00D;
      seq = '0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        seq = {seq[5:0], m1_gnt, m0_gnt};
        @(posedge clk); #1;
      end
      chk({pfx, "_rr_seq"}, 32'(seq), 32'h66);

      // locked burst of 4 from m1
      m1_lock = 1; seq = '0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        seq = {seq[5:0], m1_gnt, m0_gnt};
        @(posedge clk); #1;
      end
      chk({pfx, "_lock_seq"}, 32'(seq), 32'hAA);
      m1_req = 0; m1_lock = 0;
      @(negedge clk);
      chk({pfx, "_unlock_m0"}, 32'({m1_gnt, m0_gnt}), 32'd1);
      @(posedge clk); #1;
      m0_req = 0; m0_we = 0;

      // m1 read, m0 read raised during RD_WAIT
      m1_req = 1; m1_we = 0; m1_addr = 32'h24;
      @(negedge clk);
      chk({pfx, "_m1rd_gnt"}, 32'(m1_gnt), 32'd1);
      @(posedge clk); #1;
      m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      t_gnt = -1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (m0_gnt && t_gnt < 0) begin
          t_gnt = k;
          chk({pfx, "_chain_m1rv"}, 32'(m1_rvalid), 32'd1);
          chk({pfx, "_chain_m1data"}, m1_rdata, 32'h0BADF00D);
        end
        @(posedge clk); #1;
        if (t_gnt >= 0) begin
          m0_req = 0;
          break;
        end
      end
      chk({pfx, "_chain_gnt_cycle"}, 32'(t_gnt), 32'(LAT + 1));
      m0_req = 0;
      t_rv = -1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (m0_rvalid && t_rv < 0) begin
          t_rv = k;
          chk({pfx, "_chain_m0data"}, m0_rdata, 32'hDEADBEEF);
        end
        @(posedge clk); #1;
      end
      chk({pfx, "_chain_m0_lat"}, 32'(t_rv), 32'(LAT + 1));

      // reset during RD_WAIT drops the read
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      @(negedge clk);
      chk({pfx, "_rstrd_gnt"}, 32'(m0_gnt), 32'd1);
      @(posedge clk); #1;
      m0_req = 0; rst_n = 0;
      @(negedge clk);
      chk({pfx, "_rstrd_rdata"}, m0_rdata | m1_rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1; rv_n = 0;
      for (int k = 0; k < LAT + 4; k++) begin
        @(negedge clk);
        rv_n += int'(m0_rvalid) + int'(m1_rvalid);
        @(posedge clk); #1;
      end
      chk({pfx, "_rstrd_no_rv"}, 32'(rv_n), 32'd0);
      chk({pfx, "_rstrd_zero"}, m0_rdata | m1_rdata, 32'd0);
      chk({pfx, "_rstrd_state"}, 32'(dbg_state), 32'd0);

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
        if (!rst_n) rst_n = 1;
        else if ($urandom_range(0, 99) == 0) rst_n = 0;
        if (m0_req && exp_gnt0) m0_req = 0;
        if (m1_req && exp_gnt1) m1_req = 0;
        if (!m0_req && $urandom_range(0, 1) == 1) begin
          m0_req = 1; m0_we = 1'($urandom_range(0, 1));
          m0_addr = 32'($urandom_range(0, 63)); m0_wdata = $urandom;
        end
        if (!m1_req && $urandom_range(0, 1) == 1) begin
          m1_req = 1; m1_we = 1'($urandom_range(0, 1));
          m1_addr = 32'($urandom_range(0, 63)); m1_wdata = $urandom;
        end
        if ($urandom_range(0, 3) == 0) m1_lock = ~m1_lock;
        @(negedge clk);
        @(posedge clk); #1;
      end
      m0_req = 0; m1_req = 0; m1_lock = 0;
      repeat (6) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && !(g_inst[0].done && g_inst[1].done); t++) @(posedge clk);
    chk("bench_timeout", 32'({g_inst[1].done, g_inst[0].done}), 32'd3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
